// File: rtl/lane_pack_gather.sv
`default_nettype none
// ============================================================================
//  Module   : lane_pack_gather
//  Purpose  : Streaming lane gatherer. Collects one WIDTH-bit element per
//             accepted input beat and presents a packed LEN*WIDTH word with a
//             per-lane written mask. Lane i sits at bits
//             [WIDTH*i+WIDTH-1 : WIDTH*i].
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             in_data/in_valid/in_last/in_ready - element stream (sink side)
//             out_pack/out_mask/out_valid/out_ready - packed word (source side)
//  Revision : 1.0 - initial release
// ============================================================================
module lane_pack_gather #(
    parameter int WIDTH = 16,
    parameter int LEN   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [WIDTH*LEN-1:0]  out_pack,
    output logic [LEN-1:0]        out_mask,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int                 c_IDX_W    = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(LEN - 1);
    localparam logic               c_LEN_ONE  = (LEN == 1);

    localparam logic [0:0] c_ST_FILL = 1'b0;
    localparam logic [0:0] c_ST_FULL = 1'b1;

    logic [0:0]           r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx,   w_idx_nxt;
    logic [WIDTH*LEN-1:0] r_pack,  w_pack_nxt;
    logic [LEN-1:0]       r_mask,  w_mask_nxt;
    logic                 w_accept;

    // While a word is pending, a new element can only enter in the same
    // cycle the pending word leaves; this keeps streaming bubble-free.
    assign in_ready  = (r_state == c_ST_FILL) | out_ready;
    assign w_accept  = in_valid & in_ready;

    assign out_valid = (r_state == c_ST_FULL);
    assign out_pack  = r_pack;
    assign out_mask  = r_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FILL;
            r_idx   <= '0;
            r_pack  <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_pack  <= w_pack_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_pack_nxt  = r_pack;
        w_mask_nxt  = r_mask;

        case (r_state)
            c_ST_FILL: begin
                if (w_accept) begin
                    for (int i = 0; i < LEN; i++) begin
                        if (r_idx == c_IDX_W'(i)) begin
                            w_pack_nxt[i*WIDTH +: WIDTH] = in_data;
                            w_mask_nxt[i]                = 1'b1;
                        end
                    end
                    if (in_last || (r_idx == c_IDX_LAST)) begin
                        w_state_nxt = c_ST_FULL;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt   = r_idx + c_IDX_W'(1);
                    end
                end
            end

            default: begin
                if (out_ready) begin
                    // Word leaves; clear so unwritten lanes of the next word read 0.
                    w_pack_nxt  = '0;
                    w_mask_nxt  = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = c_ST_FILL;
                    if (in_valid) begin
                        // Simultaneous accept opens the next word at lane 0.
                        w_pack_nxt[WIDTH-1:0] = in_data;
                        w_mask_nxt[0]         = 1'b1;
                        if (in_last || c_LEN_ONE) begin
                            w_state_nxt = c_ST_FULL;
                        end else begin
                            w_idx_nxt   = c_IDX_W'(1);
                        end
                    end
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lane_pack_gather.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lane_pack_gather
//  Purpose  : Self-checking bench for lane_pack_gather (LEN=4/WIDTH=16 and
//             LEN=1/WIDTH=8 instances) against a queue-based word model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lane_pack_gather;

    localparam int c_W = 16;
    localparam int c_L = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [c_W-1:0]  in_data;
    logic            in_valid, in_last, in_ready;
    logic [c_W*c_L-1:0] out_pack;
    logic [c_L-1:0]  out_mask;
    logic            out_valid, out_ready;

    logic [7:0]      d1_in_data;
    logic            d1_in_valid, d1_in_last, d1_in_ready;
    logic [7:0]      d1_out_pack;
    logic [0:0]      d1_out_mask;
    logic            d1_out_valid, d1_out_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [c_W-1:0]     cur[$];
    bit                 m_valid;
    logic [c_W*c_L-1:0] m_pack;
    logic [c_L-1:0]     m_mask;
    bit                 m1_valid;
    logic [7:0]         m1_pack;

    always #5 clk = ~clk;

    lane_pack_gather #(.WIDTH(c_W), .LEN(c_L)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_pack  (out_pack),
        .out_mask  (out_mask),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    lane_pack_gather #(.WIDTH(8), .LEN(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (d1_in_data),
        .in_valid  (d1_in_valid),
        .in_last   (d1_in_last),
        .in_ready  (d1_in_ready),
        .out_pack  (d1_out_pack),
        .out_mask  (d1_out_mask),
        .out_valid (d1_out_valid),
        .out_ready (d1_out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, check outputs before the edge, then
    // advance the model across the edge.
    task automatic drv(input bit r, input bit v, input logic [c_W-1:0] d,
                       input bit last, input bit ordy);
        bit acc, ho, acc1, ho1;
        rst          = r;
        in_valid     = v;
        in_data      = d;
        in_last      = last;
        out_ready    = ordy;
        d1_in_valid  = ($urandom_range(0, 3) != 0);
        d1_in_data   = 8'($urandom);
        d1_in_last   = $urandom_range(0, 1) != 0;
        d1_out_ready = ($urandom_range(0, 2) != 0);
        #1;
        check("in_ready", 64'(in_ready), 64'(!m_valid || ordy));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check("out_pack", out_pack, m_pack);
            check("out_mask", 64'(out_mask), 64'(m_mask));
        end
        check("l1_in_ready", 64'(d1_in_ready), 64'(!m1_valid || d1_out_ready));
        check("l1_out_valid", 64'(d1_out_valid), 64'(m1_valid));
        if (m1_valid) begin
            check("l1_out_pack", 64'(d1_out_pack), 64'(m1_pack));
            check("l1_out_mask", 64'(d1_out_mask), 64'd1);
        end
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_pack = '0; m_mask = '0; cur.delete();
            m1_valid = 0; m1_pack = '0;
        end else begin
            acc = v && (!m_valid || ordy);
            ho  = m_valid && ordy;
            if (ho) begin
                m_valid = 0; m_pack = '0; m_mask = '0;
            end
            if (acc) begin
                cur.push_back(d);
                if (cur.size() == c_L || last) begin
                    m_pack = '0;
                    m_mask = '0;
                    foreach (cur[i]) begin
                        m_pack = m_pack | ((c_W*c_L)'(cur[i]) << (c_W * i));
                        m_mask[i] = 1'b1;
                    end
                    m_valid = 1;
                    cur.delete();
                end
            end
            acc1 = d1_in_valid && (!m1_valid || d1_out_ready);
            ho1  = m1_valid && d1_out_ready;
            if (acc1) begin
                m1_valid = 1; m1_pack = d1_in_data;
            end else if (ho1) begin
                m1_valid = 0; m1_pack = '0;
            end
        end
        #1;
    endtask

    initial begin
        m_valid = 0; m_pack = '0; m_mask = '0;
        m1_valid = 0; m1_pack = '0;

        drv(1, 0, '0, 0, 1);
        drv(1, 1, 16'hdead, 1, 0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_pack", out_pack, 64'd0);
        check("reset_mask", 64'(out_mask), 64'd0);

        // Full word
        drv(0, 1, 16'h1111, 0, 1);
        drv(0, 1, 16'h2222, 0, 1);
        drv(0, 1, 16'h3333, 0, 1);
        drv(0, 1, 16'h4444, 0, 1);
        check("full_valid", 64'(out_valid), 64'd1);
        check("full_pack", out_pack, 64'h4444_3333_2222_1111);
        check("full_mask", 64'(out_mask), 64'hf);

        // Back-to-back words across the boundary
        for (int i = 1; i <= 8; i++) drv(0, 1, 16'(i), 0, 1);
        check("b2b_pack", out_pack, 64'h0008_0007_0006_0005);

        // Drain, then a partial word closed by in_last
        drv(0, 0, '0, 0, 1);
        drv(0, 1, 16'hAAAA, 0, 1);
        drv(0, 1, 16'hBBBB, 1, 1);
        check("partial_pack", out_pack, 64'h0000_0000_BBBB_AAAA);
        check("partial_mask", 64'(out_mask), 64'h3);

        // Fill, stall, release with a simultaneous accept
        drv(0, 0, '0, 0, 1);
        for (int i = 0; i < 4; i++) drv(0, 1, 16'h0100 + 16'(i), 0, 1);
        for (int i = 0; i < 5; i++) drv(0, 1, 16'h5555, 0, 0);
        check("stall_pack", out_pack, 64'h0103_0102_0101_0100);
        drv(0, 1, 16'h5555, 0, 1);
        check("restart_valid", 64'(out_valid), 64'd0);
        check("restart_mask", 64'(out_mask), 64'h1);
        check("restart_pack", out_pack, 64'h0000_0000_0000_5555);

        // Reset mid-word discards stale lanes
        drv(0, 1, 16'h7777, 0, 1);
        drv(1, 0, '0, 0, 1);
        for (int i = 0; i < 4; i++) drv(0, 1, 16'h9999, 0, 1);
        check("postrst_pack", out_pack, 64'h9999_9999_9999_9999);
        check("postrst_mask", 64'(out_mask), 64'hf);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            drv(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0),
                16'($urandom),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lane_pack_gather.md
Name: lane_pack_gather

Overview:
- Streaming inverse of the array unpack utility: gathers one WIDTH-bit lane element per accepted beat and assembles a packed LEN*WIDTH word.
- Lane i occupies bits [WIDTH*i+WIDTH-1 : WIDTH*i], the same layout as the array pack/unpack macros.
- Sits between per-lane producers (e.g. a serial lane result stream) and wide consumers expecting a packed warp vector, with valid/ready on both sides.

Parameters:
- WIDTH, 16, bits per lane element.
- LEN, 4, lanes per packed word (>=1); lane-index counter width = max(1, log2(LEN)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  lane element.
- in_valid  input  1  in_data/in_last valid.
- in_last  input  1  element closes the current word early (partial word).
- in_ready  output  1  block accepts an element this cycle.
- out_pack  output  WIDTH*LEN  packed word.
- out_mask  output  LEN  bit i = 1 iff lane i written in this word.
- out_valid  output  1  out_pack/out_mask valid.
- out_ready  input  1  consumer takes the word this cycle.

Behaviour:
- Reset (rst=1 at clock edge): state=FILL, lane index=0, out_pack=0, out_mask=0, out_valid=0. rst overrides all handshakes; a partially filled or un-drained word is discarded.
- Accept = in_valid & in_ready. Hand-off = out_valid & out_ready.
- State FILL (out_valid=0): in_ready=1. On accept, in_data is written to lane[idx] and mask[idx] is set. idx then increments. If idx==LEN-1 or in_last=1, the block moves to FULL, out_valid=1 next cycle, and idx returns to 0.
- State FULL (out_valid=1): in_ready=out_ready (combinational). out_pack/out_mask are held stable while out_ready=0.
  - Hand-off without accept: go to FILL with out_pack=0 and out_mask=0.
  - Hand-off with accept (simultaneous): the new element starts a fresh word. out_pack is cleared, lane 0 gets in_data, out_mask=1 (only bit 0 set), idx=1. If that element also closes the word (in_last=1, or LEN==1), stay in FULL with out_valid=1. Otherwise go to FILL.
- Throughput: one element per cycle sustained with out_ready held high. No bubble at word boundaries.
- Latency: out_valid rises the cycle after the closing element's accept edge.
- Unwritten lanes in a partial word read as 0.
- in_last on the LEN-th element behaves the same as no in_last.
- LEN==1: every accepted element closes a word.
- Outputs are registered (out_*). in_ready is the only combinational output; it has no path from in_valid.
- No assertion of in_valid is lost: while in_ready=0, the producer holds its data.

Test Plan:
- Reset, then stream 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles with out_ready=1 -> one cycle after the 4th accept: out_valid=1, out_pack=0x4444_3333_2222_1111, out_mask=4'b1111. Before that, out_valid=0 and in_ready=1 throughout.
- Back-to-back 8 elements 0x0001..0x0008 with out_ready=1 -> two words, 0x0004_0003_0002_0001 then 0x0008_0007_0006_0005, on cycles 5 and 9. in_ready never drops.
- Send 0xAAAA, 0xBBBB with in_last on the 2nd -> out_pack=0x0000_0000_BBBB_AAAA, out_mask=4'b0011.
- Fill a word, hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_pack/out_mask unchanged. Raise out_ready with in_data=0x5555 -> hand-off occurs, then out_mask=4'b0001, lane0=0x5555, FILL state.
- Accept 2 elements, assert rst for one cycle, then send 0x9999 x4 -> the first word out is 0x9999_9999_9999_9999 with mask 4'b1111. No stale lanes appear.
- LEN=1, WIDTH=8: stream 0x12, 0x34 with out_ready=1 -> out_pack=0x12 then 0x34 on consecutive cycles, out_mask=1.
